// File: rtl/star_bank.sv
// Bank of collectable stars: per-star overlap test against the character, one-shot collection FSM, saturating score.
// Optional respawn countdown is compiled in with `define STAR_BANK_RESPAWN_EN.
module star_bank #(
  parameter int NUM_STARS   = 4,
  parameter int STAR_SIZE   = 12,
  parameter int CHAR_SIZE   = 12,
  parameter int RESPAWN_CYC = 1000000
) (
  input  logic                    sys_clk,
  input  logic                    RST_N,
  input  logic                    clr,
  input  logic [9:0]              char_X,
  input  logic [9:0]              char_Y,
  input  logic [9:0]              bg_pos,
  input  logic [10*NUM_STARS-1:0] star_wx,
  input  logic [10*NUM_STARS-1:0] star_wy,
  output logic [10*NUM_STARS-1:0] star_x,
  output logic [10*NUM_STARS-1:0] star_y,
  output logic [NUM_STARS-1:0]    en,
  output logic [NUM_STARS-1:0]    touch,
  output logic [7:0]              score,
  output logic                    all_done,
  output logic [2*NUM_STARS-1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    HIDDEN  = 2'd1,
    RESPAWN = 2'd2
  } star_state_t;

  logic [NUM_STARS-1:0] collect;

  for (genvar i = 0; i < NUM_STARS; i++) begin : g_star
    logic [10:0]  wx;
    logic [10:0]  wy;
    logic [10:0]  cx;
    logic [10:0]  cy;
    logic         overlap;
    logic         collect_i;
    star_state_t  state_q;
    star_state_t  state_d;

    assign wx = {1'b0, star_wx[10*i +: 10]};
    assign wy = {1'b0, star_wy[10*i +: 10]};
    assign cx = {1'b0, char_X};
    assign cy = {1'b0, char_Y};

    assign star_x[10*i +: 10] = star_wx[10*i +: 10] - bg_pos;
    assign star_y[10*i +: 10] = star_wy[10*i +: 10];

    // 11-bit compare so that box edges near 1023 never wrap back to 0.
    assign overlap = (cx <= wx + 11'(STAR_SIZE)) && (cx + 11'(CHAR_SIZE) >= wx) &&
                     (cy <= wy + 11'(STAR_SIZE)) && (cy + 11'(CHAR_SIZE) >= wy);

`ifdef STAR_BANK_RESPAWN_EN
    localparam logic [23:0] RELOAD = 24'(RESPAWN_CYC - 1);
    logic [23:0] cnt_q;

    always_ff @(posedge sys_clk or negedge RST_N) begin
      if (!RST_N) begin
        cnt_q <= '0;
      end else if (clr) begin
        cnt_q <= '0;
      end else if (state_q == HIDDEN) begin
        cnt_q <= RELOAD;
      end else if (state_q == RESPAWN && cnt_q != 24'd0) begin
        cnt_q <= cnt_q - 24'd1;
      end
    end
`endif

    always_comb begin
      state_d   = state_q;
      collect_i = 1'b0;
      if (clr) begin
        state_d = ACTIVE;
      end else begin
        case (state_q)
          ACTIVE: begin
            if (overlap) begin
              state_d   = HIDDEN;
              collect_i = 1'b1;
            end
          end
`ifdef STAR_BANK_RESPAWN_EN
          HIDDEN:  state_d = RESPAWN;
          RESPAWN: if (cnt_q == 24'd0) state_d = ACTIVE;
`endif
          default: state_d = state_q;
        endcase
      end
    end

    always_ff @(posedge sys_clk or negedge RST_N) begin
      if (!RST_N) state_q <= ACTIVE;
      else        state_q <= state_d;
    end

    assign collect[i]            = collect_i;
    assign en[i]                 = (state_q == ACTIVE);
    assign state_dbg[2*i +: 2]   = state_q;
  end

  logic [3:0] n_collect;
  logic [8:0] score_sum;

  always_comb begin
    n_collect = '0;
    for (int i = 0; i < NUM_STARS; i++) begin
      n_collect = n_collect + 4'(collect[i]);
    end
    score_sum = {1'b0, score} + 9'(n_collect);
  end

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      touch <= '0;
      score <= '0;
    end else if (clr) begin
      touch <= '0;
      score <= '0;
    end else begin
      touch <= collect;
      score <= score_sum[8] ? 8'd255 : score_sum[7:0];
    end
  end

  assign all_done = ~|en;

endmodule

// File: tb/tb_star_bank.sv
// Directed bench for star_bank: vector table for the default build, hand sequences for reset and respawn.
module tb_star_bank;

  logic        sys_clk;
  logic        RST_N;
  logic        clr;
  logic [9:0]  char_X;
  logic [9:0]  char_Y;
  logic [9:0]  bg_pos;
  logic [39:0] star_wx;
  logic [39:0] star_wy;
  logic [39:0] star_x;
  logic [39:0] star_y;
  logic [3:0]  en;
  logic [3:0]  touch;
  logic [7:0]  score;
  logic        all_done;
  logic [7:0]  state_dbg;

  int errors;
  int checks;

  star_bank #(
    .NUM_STARS  (4),
    .STAR_SIZE  (12),
    .CHAR_SIZE  (12),
    .RESPAWN_CYC(5)
  ) dut (
    .sys_clk  (sys_clk),
    .RST_N    (RST_N),
    .clr      (clr),
    .char_X   (char_X),
    .char_Y   (char_Y),
    .bg_pos   (bg_pos),
    .star_wx  (star_wx),
    .star_wy  (star_wy),
    .star_x   (star_x),
    .star_y   (star_y),
    .en       (en),
    .touch    (touch),
    .score    (score),
    .all_done (all_done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        clr;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic [9:0]  bg;
    logic [39:0] wx;
    logic [39:0] wy;
    logic [3:0]  touch;
    logic [3:0]  en;
    logic [7:0]  score;
    logic        done;
  } vec_t;

  function automatic logic [39:0] pack4(input int s0, input int s1, input int s2, input int s3);
    return {10'(s3), 10'(s2), 10'(s1), 10'(s0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input int cx, input int cy);
    clr    = c;
    char_X = 10'(cx);
    char_Y = 10'(cy);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  logic [39:0] w_x, w_y, b_x, b_y;
  vec_t        vecs[24];
  int          far;

  function automatic vec_t mk(input logic c, input int cx, input int cy, input int bg, input logic use_b,
                              input logic [3:0] t, input logic [3:0] e, input int s, input logic d);
    vec_t v;
    v.clr   = c;
    v.cx    = 10'(cx);
    v.cy    = 10'(cy);
    v.bg    = 10'(bg);
    v.wx    = use_b ? pack4(50, 100, 100, 700) : pack4(13, 100, 100, 700);
    v.wy    = use_b ? pack4(50, 100, 100, 700) : pack4(326, 100, 100, 700);
    v.touch = t;
    v.en    = e;
    v.score = 8'(s);
    v.done  = d;
    return v;
  endfunction

  initial begin
    errors  = 0;
    checks  = 0;
    far     = 900;
    w_x     = pack4(13, 100, 100, 700);
    w_y     = pack4(326, 100, 100, 700);
    RST_N   = 1'b0;
    clr     = 1'b0;
    char_X  = 10'd900;
    char_Y  = 10'd900;
    bg_pos  = 10'd0;
    star_wx = w_x;
    star_wy = w_y;

    // reset state, before any clock edge
    #3;
    chk("rst en", 64'(en), 64'hf);
    chk("rst touch", 64'(touch), 64'h0);
    chk("rst score", 64'(score), 64'd0);
    chk("rst all_done", 64'(all_done), 64'd0);
    @(negedge sys_clk);
    RST_N = 1'b1;

    // screen coordinates, including the wrap below zero
    bg_pos = 10'd20;
    #1;
    chk("star_x0 wrap", 64'(star_x[9:0]), 64'd1017);
    chk("star_x1", 64'(star_x[19:10]), 64'd80);
    chk("star_y0", 64'(star_y[9:0]), 64'd326);
    chk("star_y3", 64'(star_y[39:30]), 64'd700);

`ifndef STAR_BANK_RESPAWN_EN
    //            clr cx   cy   bg  B  touch  en     sc done
    vecs[0]  = mk(0, far, far, 0,  0, 4'h0, 4'hf, 0, 0);
    vecs[1]  = mk(0, 20,  320, 20, 0, 4'h1, 4'he, 1, 0);
    vecs[2]  = mk(0, 20,  320, 20, 0, 4'h0, 4'he, 1, 0);
    vecs[3]  = mk(0, 20,  320, 20, 0, 4'h0, 4'he, 1, 0);
    vecs[4]  = mk(0, 20,  320, 0,  1, 4'h0, 4'he, 1, 0);
    vecs[5]  = mk(0, 20,  320, 0,  1, 4'h0, 4'he, 1, 0);
    vecs[6]  = mk(0, 100, 100, 0,  0, 4'h6, 4'h8, 3, 0);
    vecs[7]  = mk(0, 100, 100, 0,  0, 4'h0, 4'h8, 3, 0);
    vecs[8]  = mk(1, 100, 100, 0,  0, 4'h0, 4'hf, 0, 0);
    vecs[9]  = mk(1, 100, 100, 0,  0, 4'h0, 4'hf, 0, 0);
    vecs[10] = mk(0, 100, 100, 0,  0, 4'h6, 4'h9, 2, 0);
    vecs[11] = mk(1, far, far, 0,  0, 4'h0, 4'hf, 0, 0);
    vecs[12] = mk(0, 63,  50,  0,  1, 4'h0, 4'hf, 0, 0);
    vecs[13] = mk(0, 37,  50,  0,  1, 4'h0, 4'hf, 0, 0);
    vecs[14] = mk(0, 62,  62,  0,  1, 4'h1, 4'he, 1, 0);
    vecs[15] = mk(1, far, far, 0,  1, 4'h0, 4'hf, 0, 0);
    vecs[16] = mk(0, 38,  38,  0,  1, 4'h1, 4'he, 1, 0);
    vecs[17] = mk(1, far, far, 0,  0, 4'h0, 4'hf, 0, 0);
    vecs[18] = mk(0, 20,  320, 0,  0, 4'h1, 4'he, 1, 0);
    vecs[19] = mk(0, 100, 100, 0,  0, 4'h6, 4'h8, 3, 0);
    vecs[20] = mk(0, 700, 700, 0,  0, 4'h8, 4'h0, 4, 1);
    vecs[21] = mk(0, far, far, 0,  0, 4'h0, 4'h0, 4, 1);
    vecs[22] = mk(0, 20,  320, 0,  0, 4'h0, 4'h0, 4, 1);
    vecs[23] = mk(1, far, far, 0,  0, 4'h0, 4'hf, 0, 0);

    for (int k = 0; k < 24; k++) begin
      @(negedge sys_clk);
      drive(vecs[k].clr, int'(vecs[k].cx), int'(vecs[k].cy));
      bg_pos  = vecs[k].bg;
      star_wx = vecs[k].wx;
      star_wy = vecs[k].wy;
      step();
      chk($sformatf("v%0d touch", k), 64'(touch), 64'(vecs[k].touch));
      chk($sformatf("v%0d en", k), 64'(en), 64'(vecs[k].en));
      chk($sformatf("v%0d score", k), 64'(score), 64'(vecs[k].score));
      chk($sformatf("v%0d all_done", k), 64'(all_done), 64'(vecs[k].done));
    end
`else
    // respawn: hidden for RESPAWN_CYC+1 = 6 edges counting the touch edge
    @(negedge sys_clk);
    drive(1'b1, far, far);
    step();
    @(negedge sys_clk);
    drive(1'b0, 20, 320);
    step();
    chk("rsp touch", 64'(touch), 64'h1);
    chk("rsp en T", 64'(en[0]), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge sys_clk);
      drive(1'b0, far, far);
      step();
      chk($sformatf("rsp en T+%0d", k), 64'(en[0]), 64'd0);
    end
    @(negedge sys_clk);
    step();
    chk("rsp en T+6", 64'(en[0]), 64'd1);
    chk("rsp score", 64'(score), 64'd1);

    // saturation: every star overlaps the character continuously
    @(negedge sys_clk);
    drive(1'b1, 100, 100);
    star_wx = pack4(100, 100, 100, 100);
    star_wy = pack4(100, 100, 100, 100);
    step();
    @(negedge sys_clk);
    clr = 1'b0;
    repeat (500) @(posedge sys_clk);
    #1;
    chk("rsp score sat", 64'(score), 64'd255);
    @(negedge sys_clk);
    drive(1'b1, far, far);
    star_wx = w_x;
    star_wy = w_y;
    step();
    @(negedge sys_clk);
    clr = 1'b0;
    step();
    chk("rsp clr score", 64'(score), 64'd0);
    chk("rsp clr en", 64'(en), 64'hf);
`endif

    // asynchronous reset mid-cycle, in the middle of a hidden/respawn period
    @(negedge sys_clk);
    drive(1'b0, 20, 320);
    step();
    chk("arst pre touch", 64'(touch), 64'h1);
    @(negedge sys_clk);
    drive(1'b0, far, far);
    step();
    step();
    chk("arst pre en", 64'(en), 64'he);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst en", 64'(en), 64'hf);
    chk("arst score", 64'(score), 64'd0);
    chk("arst touch", 64'(touch), 64'h0);
    chk("arst all_done", 64'(all_done), 64'd0);
    @(negedge sys_clk);
    RST_N = 1'b1;
    step();
    chk("arst post en", 64'(en), 64'hf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
